// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-4 Booth multiplier controller: 16x16 signed -> 32-bit product, one window per cycle.
// Optional macro BOOTH_EARLY_TERM_EN stops once all remaining multiplier windows encode zero.
module booth_seq_mult_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] m,
   input  logic [15:0] q,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] product,
   output logic        busy
);

   localparam int unsigned OP_W   = 16;
   localparam int unsigned PROD_W = 32;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned SH_W   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [OP_W-1:0]     m_r;
   logic [OP_W-1:0]     q_r;
   logic [PROD_W-1:0]   acc;
   logic [CNT_W-1:0]    cnt;

   logic [OP_W:0]       q_ext;
   logic [SH_W-1:0]     shamt;
   logic [2:0]          win;
   logic [PROD_W-1:0]   m_ext;
   logic [PROD_W-1:0]   pp_sel;
   logic [PROD_W-1:0]   sum_c;
   logic                last_c;
   logic                early_c;

   // q_ext[0] is the implicit q_r[-1] = 0; window i sits at q_ext[2i+2:2i]
   assign q_ext  = {q_r, 1'b0};
   assign shamt  = {1'b0, cnt, 1'b0};
   assign win    = q_ext[shamt +: 3];
   assign m_ext  = {{(PROD_W-OP_W){m_r[OP_W-1]}}, m_r};
   assign last_c = (cnt == CNT_W'(7));

   always_comb begin
      pp_sel = '0;
      unique case (win)
         3'b001, 3'b010: pp_sel = m_ext;
         3'b011:         pp_sel = m_ext << 1;
         3'b100:         pp_sel = ~(m_ext << 1) + PROD_W'(1);
         3'b101, 3'b110: pp_sel = ~m_ext + PROD_W'(1);
         default:        pp_sel = '0;
      endcase
   end

   assign sum_c = acc + (pp_sel << shamt);

`ifdef BOOTH_EARLY_TERM_EN
   // Remaining multiplier bits all equal <=> arithmetic shift leaves all-0 or all-1
   logic [OP_W:0] tail;
   assign tail    = (OP_W+1)'($signed(q_ext) >>> shamt);
   assign early_c = (tail == '0) || (tail == '1);
`else
   assign early_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         m_r       <= '0;
         q_r       <= '0;
         acc       <= '0;
         cnt       <= '0;
         product   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  m_r      <= m;
                  q_r      <= q;
                  acc      <= '0;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               if (early_c) begin
                  product   <= acc;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else if (last_c) begin
                  product   <= sum_c;
                  acc       <= sum_c;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  acc <= sum_c;
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Self-checking bench for booth_seq_mult_ctrl: directed corners, backpressure, reset abort, random traffic.
module tb_booth_seq_mult_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] m;
   logic [15:0] q;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   booth_seq_mult_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .m         (m),
      .q         (q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference product from plain signed arithmetic
   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p[31:0];
   endfunction

   // Cycles from acceptance to out_valid
   function automatic int ref_lat(input logic [15:0] b);
`ifdef BOOTH_EARLY_TERM_EN
      logic [16:0] bx;
      bit          same;
      bx = {b, 1'b0};
      for (int k = 0; k < 8; k++) begin
         same = 1'b1;
         for (int j = 2 * k; j <= 16; j++)
            if (bx[j] != bx[16]) same = 1'b0;
         if (same) return k + 1;
      end
      return 8;
`else
      if (b === 16'hxxxx) return 0;
      return 8;
`endif
   endfunction

   // One isolated operation; checks product and latency, then drains it
   task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b);
      int lat;
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; m = a; q = b; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(ref_lat(b)));
      chk({tag, "_product"}, product, ref_mul(a, b));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_idle_ready"}, {30'd0, in_ready, out_valid}, 32'b10);
   endtask

   initial begin
      logic [15:0] ca [6];
      logic [15:0] cb [6];
      logic [31:0] held;
      logic [31:0] expq [$];
      int lat, stale, acc_n, out_n, cyc;
      int n_rand;

      ca = '{16'd3, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234, 16'h7FFF};
      cb = '{16'd5, 16'h8000, 16'h8000, 16'h0001, 16'h0000, 16'h7FFF};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; m = '0; q = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_product",   product,        32'h0);

      for (int i = 0; i < 6; i++) run_one($sformatf("corner%0d", i), ca[i], cb[i]);

      // Backpressure: DONE held while inputs churn
      @(negedge clk);
      in_valid = 1'b1; m = 16'hFFF0; q = 16'h0123;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_product", product, ref_mul(16'hFFF0, 16'h0123));
      held = product;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'(i % 2 == 0);
         m = 16'($urandom);
         q = 16'($urandom);
         @(negedge clk);
         chk("bp_hold", {product[31:2], in_ready, out_valid} ^ {held[31:2], 2'b00},
             {product[31:2] ^ held[31:2], 2'b01} & {30'd0, 2'b11});
         chk("bp_stable", product, held);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
      run_one("after_bp", 16'h00A5, 16'hFF5A);

      // Reset during RUN step 4
      @(negedge clk);
      in_valid = 1'b1; m = 16'h1234; q = 16'h5678;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst", {29'd0, in_ready, out_valid, busy}, 32'b100);
      chk("mid_rst_product", product, 32'h0);
      stale = 0;
      out_ready = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      out_ready = 1'b0;
      chk("no_stale_result", 32'(stale), 32'd0);

      // Random traffic with stalls on both sides
      n_rand = 1500;
      acc_n = 0; out_n = 0; cyc = 0;
      while (out_n < n_rand && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         in_valid  = (acc_n < n_rand) && ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         m = 16'($urandom);
         q = 16'($urandom);
         if (in_valid && in_ready) begin
            expq.push_back(ref_mul(m, q));
            acc_n++;
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("rand_unexpected", 32'(out_n), 32'(acc_n));
            else chk($sformatf("rand%0d", out_n), product, expq.pop_front());
            out_n++;
         end
      end
      chk("rand_count", 32'(out_n), 32'(n_rand));
      chk("rand_queue_empty", 32'(expq.size()), 32'd0);
      in_valid = 1'b0; out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
